// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// drives datapath selects and write strobes from the state register, flags
// unsupported encodings and counts retired instructions.
module mc_controller #(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic [5:0]      Opcode,
    input  logic [5:0]      Funct,
    output logic            MemToReg,
    output logic            RegDst,
    output logic            IorD,
    output logic            PCSrc,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic            IRWrite,
    output logic            MemWrite,
    output logic            PCWrite,
    output logic            Branch,
    output logic            RegWrite,
    output logic [2:0]      ALUControl,
    output logic            illegal,
    output logic [3:0]      state,
    output logic [CNTW-1:0] retired
);

    localparam int unsigned SW = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [SW-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_c;

    assign state = state_q;

    // State register: clear wins, run gates advancement.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_FETCH;
        end else if (run) begin
            state_q <= state_d;
        end
    end

    // Next-state decode; unreachable codes fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore outputs from state; strobes and illegal are masked by clr or a stalled run.
    always_comb begin
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        IorD       = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                illegal = !(Opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI});
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: begin
                        ALUControl = ALU_ADD;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 1'b1;
                Branch     = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: ;
        endcase
        if (clr || !run) begin
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    // Final state of a legal instruction; leaving it retires the instruction.
    always_comb begin
        last_c = 1'b0;
        case (state_q)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB: last_c = 1'b1;
            default: last_c = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (clr) begin
            retired <= '0;
        end else if (run && last_c) begin
            retired <= retired + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed vector table, randomized run against an
// instruction-level reference model, and a counter wrap sequence.
module tb_mc_controller;

    localparam int unsigned CNTW = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_BAD  = 6'b000111;

    logic            clk;
    logic            clr;
    logic            run;
    logic [5:0]      Opcode;
    logic [5:0]      Funct;
    logic            MemToReg, RegDst, IorD, PCSrc, ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic            IRWrite, MemWrite, PCWrite, Branch, RegWrite;
    logic [2:0]      ALUControl;
    logic            illegal;
    logic [3:0]      state;
    logic [CNTW-1:0] retired;

    mc_controller #(.CNTW(CNTW)) dut (
        .clk(clk), .clr(clr), .run(run), .Opcode(Opcode), .Funct(Funct),
        .MemToReg(MemToReg), .RegDst(RegDst), .IorD(IorD), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .Branch(Branch),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .illegal(illegal),
        .state(state), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       mtr, rd, iord, pcs, asa;
        logic [1:0] asb;
        logic       irw, mw, pcw, br, rw;
        logic [2:0] alu;
    } ctl_t;

    ctl_t ctl_tab [0:10];

    function automatic ctl_t mk(input logic mtr, rd, iord, pcs, asa, input logic [1:0] asb,
                                input logic irw, mw, pcw, br, rw, input logic [2:0] alu);
        ctl_t c;
        c.mtr = mtr; c.rd = rd; c.iord = iord; c.pcs = pcs; c.asa = asa; c.asb = asb;
        c.irw = irw; c.mw = mw; c.pcw = pcw; c.br = br; c.rw = rw; c.alu = alu;
        return c;
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        if (fn == FN_ADD) return 3'b010;
        if (fn == FN_SUB) return 3'b110;
        if (fn == FN_AND) return 3'b000;
        if (fn == FN_OR)  return 3'b001;
        if (fn == FN_SLT) return 3'b111;
        return 3'b010;
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn);
        return fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT;
    endfunction

    int              m_cur = 0;
    int              m_path[$];
    logic [CNTW-1:0] m_ret = '0;

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (clr) begin
            m_cur = 0;
            m_path.delete();
            m_ret = '0;
        end else if (run) begin
            if (m_path.size() == 0) begin
                if (m_cur == 0) m_path.push_back(1);
                else if (m_cur == 1) begin
                    case (Opcode)
                        OP_LW:   begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
                        OP_SW:   begin m_path.push_back(2); m_path.push_back(5); end
                        OP_R:    begin m_path.push_back(6); m_path.push_back(7); end
                        OP_BEQ:  m_path.push_back(8);
                        OP_ADDI: begin m_path.push_back(9); m_path.push_back(10); end
                        default: ;
                    endcase
                end else m_ret = m_ret + CNTW'(1);
            end
            m_cur = (m_path.size() != 0) ? m_path.pop_front() : 0;
        end
    endtask

    task automatic model_check();
        ctl_t       e;
        logic [2:0] ealu;
        bit         g;
        bit         eill;
        e    = ctl_tab[m_cur];
        ealu = (m_cur == 6) ? alu_of(Funct) : e.alu;
        g    = run && !clr;
        eill = g && ((m_cur == 1 && !op_ok(Opcode)) || (m_cur == 6 && !fn_ok(Funct)));
        chk("m_state",    state,      m_cur);
        chk("m_MemToReg", MemToReg,   e.mtr);
        chk("m_RegDst",   RegDst,     e.rd);
        chk("m_IorD",     IorD,       e.iord);
        chk("m_PCSrc",    PCSrc,      e.pcs);
        chk("m_ALUSrcA",  ALUSrcA,    e.asa);
        chk("m_ALUSrcB",  ALUSrcB,    e.asb);
        chk("m_IRWrite",  IRWrite,    e.irw & g);
        chk("m_MemWrite", MemWrite,   e.mw & g);
        chk("m_PCWrite",  PCWrite,    e.pcw & g);
        chk("m_Branch",   Branch,     e.br & g);
        chk("m_RegWrite", RegWrite,   e.rw & g);
        chk("m_ALUCtl",   ALUControl, ealu);
        chk("m_illegal",  illegal,    eill);
        chk("m_retired",  retired,    m_ret);
    endtask

    task automatic cycle(input bit do_chk);
        @(negedge clk);
        if (do_chk) model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit         c, r;
        logic [5:0] op, fn;
        int         st;
        logic [4:0] str;   // {IRWrite, MemWrite, PCWrite, Branch, RegWrite}
        logic [2:0] alu;
        bit         ill;
        int         ret;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input bit c, r, input logic [5:0] op, fn, input int st,
                               input logic [4:0] str, input logic [2:0] alu, input bit ill,
                               input int ret);
        vec_t x;
        x.c = c; x.r = r; x.op = op; x.fn = fn; x.st = st;
        x.str = str; x.alu = alu; x.ill = ill; x.ret = ret;
        return x;
    endfunction

    initial begin
        ctl_tab[0]  = mk(0,0,0,0,0, 2'b01, 1,0,1,0,0, 3'b010);
        ctl_tab[1]  = mk(0,0,0,0,0, 2'b11, 0,0,0,0,0, 3'b010);
        ctl_tab[2]  = mk(0,0,0,0,1, 2'b10, 0,0,0,0,0, 3'b010);
        ctl_tab[3]  = mk(0,0,1,0,0, 2'b00, 0,0,0,0,0, 3'b010);
        ctl_tab[4]  = mk(1,0,0,0,0, 2'b00, 0,0,0,0,1, 3'b010);
        ctl_tab[5]  = mk(0,0,1,0,0, 2'b00, 0,1,0,0,0, 3'b010);
        ctl_tab[6]  = mk(0,0,0,0,1, 2'b00, 0,0,0,0,0, 3'b010);
        ctl_tab[7]  = mk(0,1,0,0,0, 2'b00, 0,0,0,0,1, 3'b010);
        ctl_tab[8]  = mk(0,0,0,1,1, 2'b00, 0,0,0,1,0, 3'b110);
        ctl_tab[9]  = mk(0,0,0,0,1, 2'b10, 0,0,0,0,0, 3'b010);
        ctl_tab[10] = mk(0,0,0,0,0, 2'b00, 0,0,0,0,1, 3'b010);

        // reset and lw
        vt.push_back(v(1,1,OP_LW,FN_ADD, 0,5'b00000,3'b010,0,0));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 0,5'b10100,3'b010,0,0));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 1,5'b00000,3'b010,0,0));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 2,5'b00000,3'b010,0,0));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 3,5'b00000,3'b010,0,0));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 4,5'b00001,3'b010,0,0));
        // sw
        vt.push_back(v(0,1,OP_SW,FN_ADD, 0,5'b10100,3'b010,0,1));
        vt.push_back(v(0,1,OP_SW,FN_ADD, 1,5'b00000,3'b010,0,1));
        vt.push_back(v(0,1,OP_SW,FN_ADD, 2,5'b00000,3'b010,0,1));
        vt.push_back(v(0,1,OP_SW,FN_ADD, 5,5'b01000,3'b010,0,1));
        // beq
        vt.push_back(v(0,1,OP_BEQ,FN_ADD,0,5'b10100,3'b010,0,2));
        vt.push_back(v(0,1,OP_BEQ,FN_ADD,1,5'b00000,3'b010,0,2));
        vt.push_back(v(0,1,OP_BEQ,FN_ADD,8,5'b00010,3'b110,0,2));
        // R slt, R and
        vt.push_back(v(0,1,OP_R,FN_SLT,  0,5'b10100,3'b010,0,3));
        vt.push_back(v(0,1,OP_R,FN_SLT,  1,5'b00000,3'b010,0,3));
        vt.push_back(v(0,1,OP_R,FN_SLT,  6,5'b00000,3'b111,0,3));
        vt.push_back(v(0,1,OP_R,FN_SLT,  7,5'b00001,3'b010,0,3));
        vt.push_back(v(0,1,OP_R,FN_AND,  0,5'b10100,3'b010,0,4));
        vt.push_back(v(0,1,OP_R,FN_AND,  1,5'b00000,3'b010,0,4));
        vt.push_back(v(0,1,OP_R,FN_AND,  6,5'b00000,3'b000,0,4));
        vt.push_back(v(0,1,OP_R,FN_AND,  7,5'b00001,3'b010,0,4));
        // illegal opcode, then illegal funct
        vt.push_back(v(0,1,OP_BAD,FN_ADD,0,5'b10100,3'b010,0,5));
        vt.push_back(v(0,1,OP_BAD,FN_ADD,1,5'b00000,3'b010,1,5));
        vt.push_back(v(0,1,OP_R,FN_BAD,  0,5'b10100,3'b010,0,5));
        vt.push_back(v(0,1,OP_R,FN_BAD,  1,5'b00000,3'b010,0,5));
        vt.push_back(v(0,1,OP_R,FN_BAD,  6,5'b00000,3'b010,1,5));
        vt.push_back(v(0,1,OP_R,FN_BAD,  7,5'b00001,3'b010,0,5));
        // lw with run stalls in MEMRD and MEMWB
        vt.push_back(v(0,1,OP_LW,FN_ADD, 0,5'b10100,3'b010,0,6));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 1,5'b00000,3'b010,0,6));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 2,5'b00000,3'b010,0,6));
        vt.push_back(v(0,0,OP_LW,FN_ADD, 3,5'b00000,3'b010,0,6));
        vt.push_back(v(0,0,OP_LW,FN_ADD, 3,5'b00000,3'b010,0,6));
        vt.push_back(v(0,0,OP_LW,FN_ADD, 3,5'b00000,3'b010,0,6));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 3,5'b00000,3'b010,0,6));
        vt.push_back(v(0,0,OP_LW,FN_ADD, 4,5'b00000,3'b010,0,6));
        vt.push_back(v(0,1,OP_LW,FN_ADD, 4,5'b00001,3'b010,0,6));
        // R or, cleared in EXECUTE
        vt.push_back(v(0,1,OP_R,FN_OR,   0,5'b10100,3'b010,0,7));
        vt.push_back(v(0,1,OP_R,FN_OR,   1,5'b00000,3'b010,0,7));
        vt.push_back(v(1,1,OP_R,FN_OR,   6,5'b00000,3'b001,0,7));
        // R sub after clear
        vt.push_back(v(0,1,OP_R,FN_SUB,  0,5'b10100,3'b010,0,0));
        vt.push_back(v(0,1,OP_R,FN_SUB,  1,5'b00000,3'b010,0,0));
        vt.push_back(v(0,1,OP_R,FN_SUB,  6,5'b00000,3'b110,0,0));
        vt.push_back(v(0,1,OP_R,FN_SUB,  7,5'b00001,3'b010,0,0));
        // addi
        vt.push_back(v(0,1,OP_ADDI,FN_ADD,0,5'b10100,3'b010,0,1));
        vt.push_back(v(0,1,OP_ADDI,FN_ADD,1,5'b00000,3'b010,0,1));
        vt.push_back(v(0,1,OP_ADDI,FN_ADD,9,5'b00000,3'b010,0,1));
        vt.push_back(v(0,1,OP_ADDI,FN_ADD,10,5'b00001,3'b010,0,1));
        // illegal masked by run=0, then seen; FETCH stalled; R add
        vt.push_back(v(0,1,OP_BAD,FN_ADD,0,5'b10100,3'b010,0,2));
        vt.push_back(v(0,0,OP_BAD,FN_ADD,1,5'b00000,3'b010,0,2));
        vt.push_back(v(0,1,OP_BAD,FN_ADD,1,5'b00000,3'b010,1,2));
        vt.push_back(v(0,0,OP_R,FN_ADD,  0,5'b00000,3'b010,0,2));
        vt.push_back(v(0,1,OP_R,FN_ADD,  0,5'b10100,3'b010,0,2));
        vt.push_back(v(0,1,OP_R,FN_ADD,  1,5'b00000,3'b010,0,2));
        vt.push_back(v(0,1,OP_R,FN_ADD,  6,5'b00000,3'b010,0,2));
        vt.push_back(v(0,1,OP_R,FN_ADD,  7,5'b00001,3'b010,0,2));
        vt.push_back(v(0,1,OP_R,FN_ADD,  0,5'b10100,3'b010,0,3));

        clr = 1'b1; run = 1'b0; Opcode = OP_LW; Funct = FN_ADD;
        @(posedge clk); model_step();
        @(posedge clk); model_step();
        #1;

        foreach (vt[i]) begin
            clr = vt[i].c; run = vt[i].r; Opcode = vt[i].op; Funct = vt[i].fn;
            @(negedge clk);
            chk($sformatf("row%0d state", i),    state, vt[i].st);
            chk($sformatf("row%0d strobes", i),
                {IRWrite, MemWrite, PCWrite, Branch, RegWrite}, vt[i].str);
            chk($sformatf("row%0d ALUControl", i), ALUControl, vt[i].alu);
            chk($sformatf("row%0d illegal", i),  illegal, vt[i].ill);
            chk($sformatf("row%0d retired", i),  retired, vt[i].ret);
            @(posedge clk);
            model_step();
            #1;
        end

        // Random traffic; the IR only changes while the model is in FETCH.
        for (int k = 0; k < 600; k++) begin
            clr = ($urandom_range(0, 39) == 0);
            run = ($urandom_range(0, 3) != 0);
            if (m_cur == 0) begin
                case ($urandom_range(0, 5))
                    0: Opcode = OP_LW;
                    1: Opcode = OP_SW;
                    2: Opcode = OP_R;
                    3: Opcode = OP_BEQ;
                    4: Opcode = OP_ADDI;
                    default: Opcode = 6'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0: Funct = FN_ADD;
                    1: Funct = FN_SUB;
                    2: Funct = FN_AND;
                    3: Funct = FN_OR;
                    4: Funct = FN_SLT;
                    default: Funct = 6'($urandom);
                endcase
            end
            cycle(1'b1);
        end

        // Counter wrap: 15 addi fill the 4-bit counter, the 16th wraps it.
        clr = 1'b1; run = 1'b1; Opcode = OP_ADDI; Funct = FN_ADD;
        cycle(1'b1);
        clr = 1'b0;
        for (int k = 0; k < 60; k++) cycle(1'b1);
        @(negedge clk);
        chk("wrap_full", retired, 15);
        chk("wrap_full_state", state, 0);
        #1;
        @(posedge clk); model_step(); #1;
        for (int k = 0; k < 3; k++) cycle(1'b1);
        @(negedge clk);
        chk("wrap_zero", retired, 0);
        chk("wrap_zero_state", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the 32-bit multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several clock cycles for each instruction, and drives every datapath select and write strobe from the current state. Its inputs are the datapath's decoded `Opcode`/`Funct`. It also flags unsupported encodings and counts retired instructions for bring-up and verification.

## Interface
- `CNTW`, default 16: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `run`  in  1  advance enable; low freezes the FSM.
- `Opcode`  in  6  instruction[31:26] from the IR.
- `Funct`  in  6  instruction[5:0] from the IR.
- `MemToReg`, `RegDst`, `IorD`, `PCSrc`, `ALUSrcA`  out  1 each  datapath mux selects.
- `ALUSrcB`  out  2  ALU B-operand select:
  - 00 = B
  - 01 = PC increment constant
  - 10 = SignImm
  - 11 = SignImm<<2
- `IRWrite`, `MemWrite`, `PCWrite`, `Branch`, `RegWrite`  out  1 each  write strobes.
- `ALUControl`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal`  out  1  one-cycle pulse in DECODE on an unsupported opcode, or in EXECUTE on an unsupported funct.
- `state`  out  4  current state code (debug).
- `retired`  out  CNTW  count of completed instructions.

## Operation
- **Supported opcodes:**
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
- **Supported R-type funct:**
  - add 100000
  - sub 100010
  - and 100100
  - or 100101
  - slt 101010
- **State codes:** FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10. Codes 11–15 are unreachable and return to FETCH.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), FETCH (other opcode; `illegal`=1).
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB→FETCH.
- **Outputs per state** (Moore, from the state register). Any signal not listed is 0 and ALUControl is 010.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=0, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut).
  - MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10, add.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemToReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct. An unsupported funct gives 010 and `illegal`=1; ALUWB still follows.
  - ALUWB: RegDst=1, MemToReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=1, Branch=1.
  - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1.
- **PC enable:** formed outside this block as PCWrite | (Branch & zero).
- **`retired` counter:** increments by 1 on every cycle that leaves MEMWB, MEMWR, ALUWB, BRANCH or ADDIWB with `run`=1. It wraps from all-ones to 0. Illegal opcodes do not count.

## Timing
- **Cycles per instruction:** lw 5, sw 4, R-type 4, addi 4, beq 3, illegal opcode 2 (FETCH, DECODE).
- **Opcode/Funct validity:** `Opcode`/`Funct` are valid from DECODE onward, because the IR loads at the end of FETCH.
- **Reset:** `clr`=1 at a rising edge forces state=FETCH and `retired`=0.
  - While `clr`=1, IRWrite, PCWrite, MemWrite, RegWrite, Branch and `illegal` are forced to 0 in the same cycle.
  - Reset mid-instruction abandons the instruction with no partial write.
- **Post-reset outputs:** the first cycle after reset shows the FETCH values.
- **`run`=0:**
  - State and `retired` hold.
  - All five write strobes and `illegal` are forced to 0.
  - Selects and ALUControl keep decoding from state.
  - Resuming continues from the held state.
- **Priority:** `clr` overrides `run`.

## Test plan
- Reset, then `run`=1, lw (Opcode 100011) → states 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4; `retired` 0→1 after cycle 5.
- sw then beq → sw: MemWrite=1 only in state 5 with IorD=1, 4 cycles. beq: state 8 with Branch=1, PCSrc=1, ALUControl=110, 3 cycles. `retired`=2.
- R-type with Funct 101010, 100100, 100101, 100010, 100000 → ALUControl in EXECUTE of 111, 000, 001, 110, 010; RegDst=1 in ALUWB.
- Opcode 111111 → `illegal`=1 in DECODE, returns to FETCH after 2 cycles, `retired` unchanged. Funct 000111 → `illegal`=1 in EXECUTE, ALUControl=010.
- `run` dropped for 3 cycles in MEMRD → state stays 3 with all strobes 0, then completes. `clr` asserted in EXECUTE → next cycle state=0, `retired`=0, RegWrite never pulses.
- Preload `retired` near all-ones by running 2^CNTW−1 addi instructions (use CNTW=4 for speed) → the next retire wraps `retired` to 0.
